// File: rtl/counter_pkg.sv
// Shared definitions for the Comparator-project counter blocks.
//   DEFAULT_WIDTH : default bit width of counters and compare values
//   state_t       : down-counter FSM state (IDLE=0, RUN=1, DONE=2)
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eq_compare.sv
// WIDTH-bit unsigned equality comparator, shared across Comparator blocks.
//   a, b : operands
//   eq   : 1 when a == b (combinational)
module eq_compare #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter / timer with one-shot and auto-reload modes.
//   clk, rst    : clock, synchronous active-high reset
//   load        : strobe; captures load_val as count and reload value
//   load_val    : start / reload value N (0 parks the timer in IDLE)
//   en          : count enable, one decrement per enabled RUN cycle
//   auto_reload : 1 = periodic, 0 = one-shot; sampled at each terminal event
//   cmp_val     : compare threshold for match
//   count       : current count register
//   busy        : 1 while in RUN
//   tc          : registered one-cycle terminal-count pulse
//   match       : busy && (count == cmp_val), no added latency
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             match
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             cnt_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // RUN is only ever entered with a nonzero count and reload value, so
    // count is never 0 while running and the decrement cannot underflow.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            // A load wins over a coincident terminal event: no tc, no reload.
            reload_d = load_val;
            count_d  = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == ONE) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    eq_compare #(.WIDTH(WIDTH)) u_cmp (
        .a  (count_q),
        .b  (cmp_val),
        .eq (cnt_eq)
    );

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = tc_q;
    assign match = busy && cnt_eq;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] cmp_val = '0;
    logic [7:0] count;
    logic       busy, tc, match;

    int pass_cnt = 0;
    int total    = 0;

    // reference model: what the timer should hold after each edge
    int m_count  = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_tc     = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .cmp_val     (cmp_val),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .match       (match)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // drive one cycle of inputs, advance the model, then check all outputs
    task automatic step(input bit r, input bit ld, input int lv, input bit e,
                        input bit ar, input int cv);
        rst = r; load = ld; load_val = 8'(lv); en = e; auto_reload = ar;
        cmp_val = 8'(cv);
        @(posedge clk);
        m_tc = 0;
        if (r) begin
            m_count = 0; m_reload = 0; m_run = 0;
        end else if (ld) begin
            m_count = lv; m_reload = lv; m_run = (lv != 0);
        end else if (m_run && e) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (ar) m_count = m_reload;
                else begin m_count = 0; m_run = 0; end
            end else begin
                m_count = m_count - 1;
            end
        end
        #1;
        chk("count", int'(count), m_count);
        chk("busy",  int'(busy),  int'(m_run));
        chk("tc",    int'(tc),    int'(m_tc));
        chk("match", int'(match), int'(m_run && (m_count == cv)));
    endtask

    initial begin
        int n;
        // reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 9, 1, 0, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc), 0);
        // load 5
        step(0, 1, 5, 0, 0, 0);
        chk("load5_count", int'(count), 5);
        chk("load5_busy", int'(busy), 1);

        // one-shot: 3,2,1,0
        step(0, 1, 3, 1, 0, 9);
        step(0, 0, 0, 1, 0, 9);
        step(0, 0, 0, 1, 0, 9);
        chk("os_tc_pre", int'(tc), 0);
        step(0, 0, 0, 1, 0, 9);
        chk("os_tc", int'(tc), 1);
        chk("os_count0", int'(count), 0);
        chk("os_busy", int'(busy), 0);
        step(0, 0, 0, 1, 0, 9);
        chk("os_hold", int'(count), 0);
        chk("os_tc_once", int'(tc), 0);

        // auto-reload with enable gaps: 4,3,2,2,1,4
        step(0, 1, 4, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        step(0, 0, 0, 0, 1, 9);
        chk("ar_gap_hold", int'(count), 2);
        step(0, 0, 0, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        chk("ar_reload", int'(count), 4);
        chk("ar_tc", int'(tc), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 9);
        chk("ar_no_tc", int'(tc), 0);
        step(0, 0, 0, 1, 1, 9);
        chk("ar_tc2", int'(tc), 1);

        // compare window, then cmp_val=0 in one-shot
        step(0, 1, 6, 1, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 2);
        chk("cmp_match", int'(match), 1);
        step(0, 0, 0, 1, 0, 2);
        chk("cmp_nomatch", int'(match), 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("cmp_zero", int'(match), 0);

        // load collides with terminal
        step(0, 1, 2, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        step(0, 1, 7, 1, 1, 9);
        chk("coll_count", int'(count), 7);
        chk("coll_tc", int'(tc), 0);

        // load 0 -> idle
        step(0, 1, 0, 1, 1, 9);
        chk("zero_busy", int'(busy), 0);

        // N==1 auto-reload: tc continuous
        step(0, 1, 1, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        chk("n1_tc", int'(tc), 1);

        // load 255: tc after 255 enabled cycles
        step(0, 1, 255, 1, 0, 9);
        n = 0;
        while (!tc && n < 300) begin
            step(0, 0, 0, 1, 0, 9);
            n++;
        end
        chk("max_period", n, 255);

        // reset mid-count at terminal cycle
        step(0, 1, 2, 1, 1, 9);
        step(0, 0, 0, 1, 1, 9);
        step(1, 0, 0, 1, 1, 9);
        chk("rstmid_count", int'(count), 0);
        chk("rstmid_tc", int'(tc), 0);
        chk("rstmid_busy", int'(busy), 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit r, ld;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 19) == 0);
            step(r, ld, (ld && $urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                          : $urandom_range(0, 6),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
